// File: rtl/program_loader.sv
// Copies a program image word by word from the disk read port into instruction memory.
// One word is in flight at a time; every output is registered.
module program_loader #(
  parameter int unsigned MEM_WORDS  = 201,
  parameter logic [2:0]  WRITE_CODE = 3'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_base,
  input  logic [31:0] dst_base,
  input  logic [31:0] length,
  output logic        disk_req,
  output logic [31:0] disk_addr,
  input  logic        disk_ack,
  input  logic [31:0] disk_data,
  output logic [31:0] entradaDeInstrucao,
  output logic [31:0] posicaoParaSalvarInstrucao,
  output logic [2:0]  controleSalvaInstrucao,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {StIdle, StReq, StWrite, StDone, StErr} state_t;

  state_t      state_q;
  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [31:0] len_q;
  logic [31:0] count_q;

  logic [32:0] dst_end;
  logic        too_long;
  logic        last_word;

  // 33-bit sum so a destination near the top of the address space cannot wrap into range.
  assign dst_end   = {1'b0, dst_base} + {1'b0, length};
  assign too_long  = dst_end > 33'(MEM_WORDS);
  assign last_word = (count_q + 32'd1) == len_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q                    <= StIdle;
      src_q                      <= '0;
      dst_q                      <= '0;
      len_q                      <= '0;
      count_q                    <= '0;
      disk_req                   <= 1'b0;
      disk_addr                  <= '0;
      entradaDeInstrucao         <= '0;
      posicaoParaSalvarInstrucao <= '0;
      controleSalvaInstrucao     <= 3'd0;
      busy                       <= 1'b0;
      done                       <= 1'b0;
      error                      <= 1'b0;
    end else begin
      done                   <= 1'b0;
      error                  <= 1'b0;
      controleSalvaInstrucao <= 3'd0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            src_q   <= src_base;
            dst_q   <= dst_base;
            len_q   <= length;
            count_q <= '0;
            if (length == 32'd0) begin
              state_q <= StDone;
              done    <= 1'b1;
              busy    <= 1'b1;
            end else if (too_long) begin
              state_q <= StErr;
              error   <= 1'b1;
            end else begin
              state_q   <= StReq;
              disk_req  <= 1'b1;
              disk_addr <= src_base;
              busy      <= 1'b1;
            end
          end
        end
        StReq: begin
          if (disk_ack) begin
            state_q                    <= StWrite;
            disk_req                   <= 1'b0;
            entradaDeInstrucao         <= disk_data;
            posicaoParaSalvarInstrucao <= dst_q + count_q;
            controleSalvaInstrucao     <= WRITE_CODE;
          end
        end
        StWrite: begin
          if (last_word) begin
            state_q <= StDone;
            done    <= 1'b1;
          end else begin
            state_q   <= StReq;
            count_q   <= count_q + 32'd1;
            disk_req  <= 1'b1;
            disk_addr <= src_q + count_q + 32'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        StErr: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a schedule-based model predicts every output each cycle.
module tb_program_loader;

  localparam logic [2:0] WRITE_CODE = 3'd1;
  localparam int KIDLE = 0, KNORM = 1, KZERO = 2, KERR = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_base, dst_base, length;
  logic        disk_req;
  logic [31:0] disk_addr;
  logic        disk_ack;
  logic [31:0] disk_data;
  logic [31:0] entradaDeInstrucao, posicaoParaSalvarInstrucao;
  logic [2:0]  controleSalvaInstrucao;
  logic        busy, done, error;

  program_loader #(.MEM_WORDS(201), .WRITE_CODE(WRITE_CODE)) dut (
    .clock                      (clock),
    .reset                      (reset),
    .start                      (start),
    .src_base                   (src_base),
    .dst_base                   (dst_base),
    .length                     (length),
    .disk_req                   (disk_req),
    .disk_addr                  (disk_addr),
    .disk_ack                   (disk_ack),
    .disk_data                  (disk_data),
    .entradaDeInstrucao         (entradaDeInstrucao),
    .posicaoParaSalvarInstrucao (posicaoParaSalvarInstrucao),
    .controleSalvaInstrucao     (controleSalvaInstrucao),
    .busy                       (busy),
    .done                       (done),
    .error                      (error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Current job as the model sees it: per-word wait counts, data and first REQ cycle.
  int          j_kind = KIDLE;
  logic [31:0] j_src, j_dst, j_len;
  int          w [16];
  logic [31:0] dat [16];
  int          rs [16];
  int          done_c;
  // Values the address/data outputs must be holding.
  logic [31:0] m_addr = '0, m_pos = '0, m_data = '0;
  bit          g_ack, g_inreq;
  int          g_k;
  int          obs_done, obs_err, obs_writes, obs_req;
  logic [31:0] obs_last_pos;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  task automatic check_cycle(input int c);
    logic       e_req, e_busy, e_done, e_err;
    logic [2:0] e_ctrl;
    e_req = 0; e_busy = 0; e_done = 0; e_err = 0; e_ctrl = 3'd0;
    g_ack = 0; g_inreq = 0; g_k = 0;
    if (c >= 1) begin
      if (j_kind == KERR && c == 1) e_err = 1;
      if (j_kind == KZERO && c == 1) begin e_done = 1; e_busy = 1; end
      if (j_kind == KNORM) begin
        for (int k = 0; k < int'(j_len); k++) begin
          if (c >= rs[k] && c <= rs[k] + w[k]) begin
            e_req = 1; e_busy = 1; g_inreq = 1;
            m_addr = j_src + 32'(k);
            if (c == rs[k] + w[k]) begin g_ack = 1; g_k = k; end
          end
          if (c == rs[k] + w[k] + 1) begin
            e_ctrl = WRITE_CODE; e_busy = 1;
            m_pos = j_dst + 32'(k);
            m_data = dat[k];
          end
        end
        if (c == done_c) begin e_done = 1; e_busy = 1; end
      end
    end
    chk("disk_req", c, 32'(disk_req), 32'(e_req));
    chk("disk_addr", c, disk_addr, m_addr);
    chk("ctrl", c, 32'(controleSalvaInstrucao), 32'(e_ctrl));
    chk("wr_addr", c, posicaoParaSalvarInstrucao, m_pos);
    chk("wr_data", c, entradaDeInstrucao, m_data);
    chk("busy", c, 32'(busy), 32'(e_busy));
    chk("done", c, 32'(done), 32'(e_done));
    chk("error", c, 32'(error), 32'(e_err));
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_req"}, 0, 32'(disk_req), 32'd0);
    chk({nm, "_addr"}, 0, disk_addr, 32'd0);
    chk({nm, "_ctrl"}, 0, 32'(controleSalvaInstrucao), 32'd0);
    chk({nm, "_wpos"}, 0, posicaoParaSalvarInstrucao, 32'd0);
    chk({nm, "_wdat"}, 0, entradaDeInstrucao, 32'd0);
    chk({nm, "_busy"}, 0, 32'(busy), 32'd0);
    chk({nm, "_done"}, 0, 32'(done), 32'd0);
    chk({nm, "_err"}, 0, 32'(error), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    j_kind = KIDLE;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_cycle(0);
      disk_ack  = 1'($urandom);
      disk_data = $urandom;
    end
  endtask

  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                         input int fixw, input bit repulse, input bit start_end,
                         input int abort_word);
    int r;
    j_src = src; j_dst = dst; j_len = len;
    if (len == 0) j_kind = KZERO;
    else if ({1'b0, dst} + {1'b0, len} > 33'd201) j_kind = KERR;
    else j_kind = KNORM;
    done_c = 1;
    if (j_kind == KNORM) begin
      r = 1;
      for (int k = 0; k < int'(len); k++) begin
        w[k]   = (fixw >= 0) ? fixw : int'($urandom_range(0, 3));
        dat[k] = $urandom;
        rs[k]  = r;
        r      = r + w[k] + 2;
      end
      done_c = r;
    end
    @(negedge clock);
    check_cycle(0);
    start = 1'b1; src_base = src; dst_base = dst; length = len;
    disk_ack = 1'($urandom); disk_data = $urandom;
    obs_done = -1; obs_err = -1; obs_writes = 0; obs_req = 0; obs_last_pos = '0;
    for (int c = 1; c <= done_c + 2; c++) begin
      @(negedge clock);
      check_cycle(c);
      if (done) obs_done = c;
      if (error) obs_err = c;
      if (disk_req) obs_req++;
      if (controleSalvaInstrucao == WRITE_CODE) begin
        obs_writes++;
        obs_last_pos = posicaoParaSalvarInstrucao;
      end
      if (abort_word >= 0 && j_kind == KNORM && c == rs[abort_word]) begin
        #1 reset = 1'b0;
        #1 check_all_zero("async_rst");
        m_addr = '0; m_pos = '0; m_data = '0;
        j_kind = KIDLE;
        start = 1'b0; disk_ack = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        return;
      end
      start = (repulse && c == 3) || (start_end && c == done_c);
      if (start) begin
        src_base = $urandom; dst_base = $urandom_range(0, 100); length = $urandom_range(1, 4);
      end
      disk_ack  = g_ack ? 1'b1 : (g_inreq ? 1'b0 : 1'($urandom));
      disk_data = g_ack ? dat[g_k] : $urandom;
    end
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle 0 got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] s, d, l;
    reset = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; length = '0;
    disk_ack = 1'b0; disk_data = '0;
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    idle_cycles(2);

    // Directed loads with literal expectations pinning the model.
    run_job(32'd100, 32'd10, 32'd3, 0, 1'b0, 1'b0, -1);
    chk("t1_done_cycle", 0, 32'(obs_done), 32'd7);
    chk("t1_writes", 0, 32'(obs_writes), 32'd3);
    chk("t1_last_pos", 0, obs_last_pos, 32'd12);
    run_job(32'd500, 32'd0, 32'd2, 3, 1'b0, 1'b0, -1);
    chk("t2_done_cycle", 0, 32'(obs_done), 32'd11);
    chk("t2_writes", 0, 32'(obs_writes), 32'd2);
    run_job(32'd7, 32'd5, 32'd0, 0, 1'b0, 1'b1, -1);
    chk("t3_done_cycle", 0, 32'(obs_done), 32'd1);
    chk("t3_reqs", 0, 32'(obs_req + obs_writes), 32'd0);
    run_job(32'd0, 32'd199, 32'd5, 0, 1'b0, 1'b1, -1);
    chk("t4_err_cycle", 0, 32'(obs_err), 32'd1);
    chk("t4_reqs", 0, 32'(obs_req + obs_writes), 32'd0);
    run_job(32'd40, 32'd196, 32'd5, 0, 1'b0, 1'b0, -1);
    chk("t4b_done_cycle", 0, 32'(obs_done), 32'd11);
    chk("t4b_last_pos", 0, obs_last_pos, 32'd200);
    run_job(32'd100, 32'd10, 32'd3, 0, 1'b1, 1'b0, -1);
    chk("t5_done_cycle", 0, 32'(obs_done), 32'd7);
    chk("t5_writes", 0, 32'(obs_writes), 32'd3);
    run_job(32'd300, 32'd20, 32'd3, -1, 1'b0, 1'b0, 2);
    idle_cycles(4);
    run_job(32'd9, 32'd3, 32'd1, 0, 1'b0, 1'b0, -1);
    chk("t6_done_cycle", 0, 32'(obs_done), 32'd3);
    chk("t6_last_pos", 0, obs_last_pos, 32'd3);

    // Randomized loads, including wrapping sources and out-of-range destinations.
    for (int i = 0; i < 40; i++) begin
      l = $urandom_range(0, 8);
      d = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                      : $urandom_range(0, 205);
      s = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : $urandom;
      run_job(s, d, l, -1, 1'($urandom), 1'($urandom), -1);
      if ($urandom_range(0, 3) == 0) idle_cycles(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
